hdmi_tpg_gen: RTL and testbench
===============================

Name: hdmi_tpg_gen

Overview:
- Parametrised HDMI test-pattern generator driving the ADV7513 in YCbCr 4:2:2 8+8-bit mode.
- Generalises the fixed 720p colour-bar tester:
  - any CEA-style timing via parameters
  - four selectable patterns, switched glitch-free at frame boundaries
  - a frame counter
  - configurable sync polarity
- Sits between the pixel PLL and the ADV7513 pins; used for bring-up before the HDR pipeline is connected.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FRONT, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BACK, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FRONT, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BACK, 20, vertical back porch (lines)
- CNT_W, 13, width of h/v counters; must hold max(HTOTAL, VTOTAL)-1
- HS_ACT, 1'b0, asserted level of hsync
- VS_ACT, 1'b0, asserted level of vsync
- CHK_LOG2, 5, checker square size = 2^CHK_LOG2 pixels

Ports:
- pixel_clk, input, 1, pixel clock
- reset_n, input, 1, asynchronous active-low reset
- mode, input, 2, pattern select: 0 bars, 1 ramp, 2 solid, 3 checker; quasi-static
- solid_y, input, 8, Y for solid mode
- solid_cb, input, 8, Cb for solid mode
- solid_cr, input, 8, Cr for solid mode
- data_enable, output, 1, active video
- hsync, output, 1, horizontal sync
- vsync, output, 1, vertical sync
- data_Y, output, 8, luma
- data_Cb_Cr, output, 8, multiplexed chroma
- frame_start, output, 1, one-cycle pulse aligned with first active pixel of a frame
- frame_cnt, output, 16, frames completed, wraps

Behaviour:
- HTOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; VTOTAL analogous.
- h_cnt runs 0..HTOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, runs 0..VTOTAL-1 and wraps.
- Line order: active [0, H_ACTIVE-1], front porch, sync, back porch. Frame order is the same with lines.
- hsync = HS_ACT for h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
- vsync = VS_ACT for v_cnt in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1]. vsync changes on the same cycle as the h_cnt wrap.
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Pipeline: counters → stage 1 (pattern compute) → stage 2 (output registers). All outputs, including syncs, come out of stage 2, so every output lags the counters by exactly 2 cycles and all outputs are mutually aligned.
- Reset values:
  - counters 0
  - data_enable 0
  - hsync = ~HS_ACT, vsync = ~VS_ACT
  - data_Y 8'h10, data_Cb_Cr 8'h80
  - frame_start 0, frame_cnt 0
  - latched mode 0
- Reset is honoured mid-line or mid-frame; the first active pixel comes out 2 cycles after release.
- Blanking (de=0): data_Y=8'h10, data_Cb_Cr=8'h80.
- 4:2:2 chroma: x = h_cnt in active region. data_Cb_Cr = Cb when x[0]=0, Cr when x[0]=1. Parity restarts at x=0 on every line.
- mode and solid_* are sampled into shadow registers only at h_cnt=0, v_cnt=0. A mid-frame change has no effect until the next frame.
- frame_start pulses at the output of pixel (0,0). frame_cnt increments in the same cycle, modulo 2^16.
- Bars (mode 0), BT.601 limited 100%:
  - bar index = (x*8)/H_ACTIVE, computed by comparing x against 7 constant thresholds; no divider.
  - Values are Y,Cb,Cr in order:
    - white 235,128,128
    - yellow 210,16,146
    - cyan 170,166,16
    - green 145,54,34
    - magenta 106,202,222
    - red 81,90,240
    - blue 41,240,110
    - black 16,128,128
- Ramp (mode 1): Y = 16 + (x[7:0] mod 220), wraps every 220 pixels; Cb=Cr=128.
- Solid (mode 2): shadowed solid_* values.
- Checker (mode 3): Y = 235 if (x[CHK_LOG2] ^ y[CHK_LOG2]) else 16; Cb=Cr=128, where y = v_cnt.

Optional Feature:
- Macro TPG_BORDER_EN.
- When defined: pixels with x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 are forced to Y=235, Cb=Cr=128 in all modes, with no latency change.
- When undefined: no border logic; pattern is unmodified at the edges.

Decomposition:
- Package hdmi_tpg_pkg:
  - tpg_mode_t enum: MODE_BARS, MODE_RAMP, MODE_SOLID, MODE_CHECK
  - YCbCr struct typedef, 8 bits per field
  - BAR_LUT constant array of 8 YCbCr entries
  - BLANK_Y = 8'h10, BLANK_C = 8'h80
- Sub-module hdmi_timing_core: owns h/v counters and raw hs/vs/de/x/y generation. Reusable by the future HDR output stage.

Test Plan:
- Default params, 2 frames after reset → hsync low 40 clocks per line with period 1650; vsync low 5 lines with period 750 lines; 1280×720 de-high pixels per frame; frame_cnt=2.
- Mode 0 → line 0 pixels 0,1: data_Y=235 with Cb_Cr=128,128; pixel 160: Y=210, Cb_Cr=16 (even x); pixel 1279: Y=16.
- Mode 1 → x=0: Y=16; x=219: Y=235; x=220: Y=16; Cb_Cr constant 128 in active region.
- Mode changed 0→2 (solid 81/90/240) at mid-frame line 300 → rest of frame stays bars; next frame: frame_start pulse and all active pixels Y=81, Cb_Cr alternating 90/240.
- reset_n pulsed low at line 400 pixel 500 → outputs immediately show reset values; first de=1 and frame_start 2 cycles after release; frame_cnt=0.
- Small params H_ACTIVE=16, all porches=2, TPG_BORDER_EN defined, mode 3 → row 0 all Y=235; interior checker per CHK_LOG2=1; x=15 column Y=235.

Source files
------------

// File: rtl/hdmi_tpg_pkg.sv
// Shared types and constants for the HDMI YCbCr 4:2:2 test-pattern generator.
package hdmi_tpg_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_SOLID = 2'd2,
    MODE_CHECK = 2'd3
  } tpg_mode_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycbcr_t;

  localparam logic [7:0] BLANK_Y   = 8'h10;
  localparam logic [7:0] BLANK_C   = 8'h80;
  localparam logic [7:0] WHITE_Y   = 8'd235;
  localparam logic [7:0] BLACK_Y   = 8'd16;
  localparam logic [7:0] NEUTRAL_C = 8'd128;

  // BT.601 limited-range 100% colour bars, left to right.
  localparam ycbcr_t BAR_LUT [8] = '{
    '{8'd235, 8'd128, 8'd128},
    '{8'd210, 8'd16,  8'd146},
    '{8'd170, 8'd166, 8'd16 },
    '{8'd145, 8'd54,  8'd34 },
    '{8'd106, 8'd202, 8'd222},
    '{8'd81,  8'd90,  8'd240},
    '{8'd41,  8'd240, 8'd110},
    '{8'd16,  8'd128, 8'd128}
  };

  // Luma ramp 16..235 driven by the low byte of the column index.
  function automatic logic [7:0] ramp_luma(input logic [7:0] x8);
    return (x8 < 8'd220) ? (x8 + 8'd16) : (x8 - 8'd204);
  endfunction

endpackage

// File: rtl/hdmi_timing_core.sv
// Raster timing: h/v counters plus raw sync, data-enable and pixel coordinates.
// Shared with the HDR output stage, so it carries no pattern knowledge.
module hdmi_timing_core #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FRONT  = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BACK   = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FRONT  = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BACK   = 20,
  parameter int   CNT_W    = 13,
  parameter logic HS_ACT   = 1'b0,
  parameter logic VS_ACT   = 1'b0
) (
  input  logic             pixel_clk,
  input  logic             reset_n,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             de,
  output logic             hs,
  output logic             vs,
  output logic             origin
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  assign x      = h_cnt;
  assign y      = v_cnt;
  assign de     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs     = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? HS_ACT : ~HS_ACT;
  assign vs     = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? VS_ACT : ~VS_ACT;
  assign origin = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/hdmi_tpg_gen.sv
// HDMI test-pattern generator for the ADV7513 (YCbCr 4:2:2, 8+8 bit).
// Define TPG_BORDER_EN to force a one-pixel white border around the active area.
module hdmi_tpg_gen
  import hdmi_tpg_pkg::*;
#(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FRONT  = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BACK   = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FRONT  = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BACK   = 20,
  parameter int   CNT_W    = 13,
  parameter logic HS_ACT   = 1'b0,
  parameter logic VS_ACT   = 1'b0,
  parameter int   CHK_LOG2 = 5
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic [1:0]  mode,
  input  logic [7:0]  solid_y,
  input  logic [7:0]  solid_cb,
  input  logic [7:0]  solid_cr,
  output logic        data_enable,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  data_Y,
  output logic [7:0]  data_Cb_Cr,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [CNT_W-1:0] CHK_MASK = CNT_W'(1) << CHK_LOG2;

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             raw_de;
  logic             raw_hs;
  logic             raw_vs;
  logic             at_origin;

  tpg_mode_t mode_q;
  tpg_mode_t eff_mode;
  ycbcr_t    solid_in;
  ycbcr_t    solid_q;
  ycbcr_t    eff_solid;
  ycbcr_t    px;
  logic [2:0] bar_idx;
  logic       chk_on;
  logic       on_border;

  logic       s1_de;
  logic       s1_hs;
  logic       s1_vs;
  logic       s1_first;
  logic [7:0] s1_y;
  logic [7:0] s1_c;

  hdmi_timing_core #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .CNT_W    (CNT_W),
    .HS_ACT   (HS_ACT),
    .VS_ACT   (VS_ACT)
  ) u_timing (
    .pixel_clk (pixel_clk),
    .reset_n   (reset_n),
    .x         (x),
    .y         (y),
    .de        (raw_de),
    .hs        (raw_hs),
    .vs        (raw_vs),
    .origin    (at_origin)
  );

  assign solid_in = {solid_y, solid_cb, solid_cr};
  assign chk_on   = |((x ^ y) & CHK_MASK);

`ifdef TPG_BORDER_EN
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);
  assign on_border = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
`else
  assign on_border = 1'b0;
`endif

  // Bar index = floor(x*8/H_ACTIVE) via seven constant ceil thresholds.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (x >= CNT_W'((k * H_ACTIVE + 7) / 8)) bar_idx = 3'(k);
    end
  end

  // Pixel (0,0) uses the live inputs so the new frame's settings apply from its first pixel.
  always_comb begin
    eff_mode  = at_origin ? tpg_mode_t'(mode) : mode_q;
    eff_solid = at_origin ? solid_in : solid_q;
    px        = '{BLANK_Y, BLANK_C, BLANK_C};
    case (eff_mode)
      MODE_BARS:  px = BAR_LUT[bar_idx];
      MODE_RAMP:  px = '{ramp_luma(x[7:0]), NEUTRAL_C, NEUTRAL_C};
      MODE_SOLID: px = eff_solid;
      MODE_CHECK: px = '{chk_on ? WHITE_Y : BLACK_Y, NEUTRAL_C, NEUTRAL_C};
    endcase
    if (on_border) px = '{WHITE_Y, NEUTRAL_C, NEUTRAL_C};
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q  <= MODE_BARS;
      solid_q <= '{BLANK_Y, BLANK_C, BLANK_C};
    end else if (at_origin) begin
      mode_q  <= tpg_mode_t'(mode);
      solid_q <= solid_in;
    end
  end

  // Stage 1: pattern result plus the timing flags that travel with it.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_de    <= 1'b0;
      s1_hs    <= ~HS_ACT;
      s1_vs    <= ~VS_ACT;
      s1_first <= 1'b0;
      s1_y     <= BLANK_Y;
      s1_c     <= BLANK_C;
    end else begin
      s1_de    <= raw_de;
      s1_hs    <= raw_hs;
      s1_vs    <= raw_vs;
      s1_first <= at_origin;
      s1_y     <= raw_de ? px.y : BLANK_Y;
      s1_c     <= raw_de ? (x[0] ? px.cr : px.cb) : BLANK_C;
    end
  end

  // Stage 2: pin registers, so syncs and pixel data leave together.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_enable <= 1'b0;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      data_Y      <= BLANK_Y;
      data_Cb_Cr  <= BLANK_C;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      data_enable <= s1_de;
      hsync       <= s1_hs;
      vsync       <= s1_vs;
      data_Y      <= s1_y;
      data_Cb_Cr  <= s1_c;
      frame_start <= s1_first;
      if (s1_first) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hdmi_tpg_gen.sv
// Scoreboard bench for hdmi_tpg_gen using a reduced raster so whole frames fit in a short run.
module tb_hdmi_tpg_gen;

  localparam int   HA    = 250;
  localparam int   HF    = 4;
  localparam int   HSW   = 6;
  localparam int   HB    = 8;
  localparam int   VA    = 6;
  localparam int   VF    = 2;
  localparam int   VSW   = 2;
  localparam int   VB    = 2;
  localparam int   CW    = 9;
  localparam int   CHK   = 1;
  localparam logic HSA   = 1'b0;
  localparam logic VSA   = 1'b1;
  localparam int   HT    = HA + HF + HSW + HB;
  localparam int   VT    = VA + VF + VSW + VB;
  localparam int   FRAME = HT * VT;

  localparam logic [35:0] RESET_TUPLE = {1'b0, 1'b0, ~HSA, ~VSA, 8'h10, 8'h80, 16'h0000};
  localparam logic [7:0] BAR_Y  [8] = '{8'd235, 8'd210, 8'd170, 8'd145, 8'd106, 8'd81, 8'd41, 8'd16};
  localparam logic [7:0] BAR_CB [8] = '{8'd128, 8'd16, 8'd166, 8'd54, 8'd202, 8'd90, 8'd240, 8'd128};
  localparam logic [7:0] BAR_CR [8] = '{8'd128, 8'd146, 8'd16, 8'd34, 8'd222, 8'd240, 8'd110, 8'd128};

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b1;
  logic [1:0]  mode      = 2'd0;
  logic [7:0]  solid_y   = 8'd0;
  logic [7:0]  solid_cb  = 8'd0;
  logic [7:0]  solid_cr  = 8'd0;
  logic        data_enable;
  logic        hsync;
  logic        vsync;
  logic [7:0]  data_Y;
  logic [7:0]  data_Cb_Cr;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic [35:0] observed;

  int compared   = 0;
  int mismatched = 0;

  logic [35:0] exp_q [$];
  int          m_h;
  int          m_v;
  logic [1:0]  m_mode;
  logic [7:0]  m_sy;
  logic [7:0]  m_scb;
  logic [7:0]  m_scr;
  logic [15:0] m_fcnt;
  logic [15:0] px0_exp;
  logic [15:0] px1_exp;

  always #5 pixel_clk = ~pixel_clk;

  hdmi_tpg_gen #(
    .H_ACTIVE (HA),
    .H_FRONT  (HF),
    .H_SYNC   (HSW),
    .H_BACK   (HB),
    .V_ACTIVE (VA),
    .V_FRONT  (VF),
    .V_SYNC   (VSW),
    .V_BACK   (VB),
    .CNT_W    (CW),
    .HS_ACT   (HSA),
    .VS_ACT   (VSA),
    .CHK_LOG2 (CHK)
  ) dut (
    .pixel_clk   (pixel_clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .solid_y     (solid_y),
    .solid_cb    (solid_cb),
    .solid_cr    (solid_cr),
    .data_enable (data_enable),
    .hsync       (hsync),
    .vsync       (vsync),
    .data_Y      (data_Y),
    .data_Cb_Cr  (data_Cb_Cr),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  assign observed = {frame_start, data_enable, hsync, vsync, data_Y, data_Cb_Cr, frame_cnt};

  task automatic checkOutput(input string tag, input logic [35:0] got, input logic [35:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected output tuple for raster position (h,v) under the given frame settings.
  function automatic logic [35:0] model_out(input int h, input int v, input logic [1:0] md,
                                            input logic [7:0] sy, input logic [7:0] scb,
                                            input logic [7:0] scr, input logic [15:0] fcnt,
                                            input logic fs);
    logic de;
    logic hs;
    logic vs;
    logic [7:0] yy;
    logic [7:0] cc;
    int idx;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HF && h < HA + HF + HSW) ? HSA : ~HSA;
    vs = (v >= VA + VF && v < VA + VF + VSW) ? VSA : ~VSA;
    yy = 8'h10;
    cc = 8'h80;
    if (de) begin
      case (md)
        2'd0: begin
          idx = (h * 8) / HA;
          yy  = BAR_Y[idx];
          cc  = (h % 2 == 0) ? BAR_CB[idx] : BAR_CR[idx];
        end
        2'd1: begin
          yy = 8'(((h % 256) % 220) + 16);
          cc = 8'd128;
        end
        2'd2: begin
          yy = sy;
          cc = (h % 2 == 0) ? scb : scr;
        end
        default: begin
          yy = ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? 8'd235 : 8'd16;
          cc = 8'd128;
        end
      endcase
`ifdef TPG_BORDER_EN
      if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
        yy = 8'd235;
        cc = 8'd128;
      end
`endif
    end
    return {fs, de, hs, vs, yy, cc, fcnt};
  endfunction

  // Reference raster: pushes the expected tuple for the position entering the DUT this edge.
  always @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_h    <= 0;
      m_v    <= 0;
      m_mode <= 2'd0;
      m_sy   <= 8'd0;
      m_scb  <= 8'd0;
      m_scr  <= 8'd0;
      m_fcnt <= 16'd0;
    end else begin
      if (m_h == 0 && m_v == 0) begin
        exp_q.push_back(model_out(m_h, m_v, mode, solid_y, solid_cb, solid_cr, m_fcnt + 16'd1, 1'b1));
        m_mode <= mode;
        m_sy   <= solid_y;
        m_scb  <= solid_cb;
        m_scr  <= solid_cr;
        m_fcnt <= m_fcnt + 16'd1;
      end else begin
        exp_q.push_back(model_out(m_h, m_v, m_mode, m_sy, m_scb, m_scr, m_fcnt, 1'b0));
      end
      if (m_h == HT - 1) begin
        m_h <= 0;
        m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  // Two-deep latency: until the pipe has filled, the pins must still show reset values.
  always @(negedge pixel_clk) begin
    if (exp_q.size() >= 2) checkOutput("stream", observed, exp_q.pop_front());
    else checkOutput("reset_state", observed, RESET_TUPLE);
  end

  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] sy, input logic [7:0] scb,
                               input logic [7:0] scr);
    @(negedge pixel_clk);
    mode     = m;
    solid_y  = sy;
    solid_cb = scb;
    solid_cr = scr;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge pixel_clk);
  endtask

  task automatic waitFrameStart(input string tag);
    int n = 0;
    @(negedge pixel_clk);
    while (frame_start !== 1'b1 && n < 2 * FRAME) begin
      @(negedge pixel_clk);
      n++;
    end
    checkOutput(tag, 36'(frame_start), 36'd1);
  endtask

  task automatic measureFrame(input logic [15:0] end_cnt);
    int de_n = 0;
    int hs_n = 0;
    int vs_n = 0;
    waitFrameStart("fs_before_measure");
    for (int i = 0; i < FRAME; i++) begin
      if (data_enable === 1'b1) de_n++;
      if (hsync === HSA) hs_n++;
      if (vsync === VSA) vs_n++;
      @(negedge pixel_clk);
    end
    checkOutput("de_pixels_per_frame", 36'(de_n), 36'(HA * VA));
    checkOutput("hsync_active_cycles", 36'(hs_n), 36'(HSW * VT));
    checkOutput("vsync_active_cycles", 36'(vs_n), 36'(VSW * HT));
    checkOutput("frame_period_pulse", 36'(frame_start), 36'd1);
    checkOutput("frame_cnt", 36'(frame_cnt), 36'(end_cnt));
  endtask

  initial begin
`ifdef TPG_BORDER_EN
    px0_exp = {8'd235, 8'd128};
    px1_exp = {8'd235, 8'd128};
`else
    px0_exp = {8'd81, 8'd90};
    px1_exp = {8'd81, 8'd240};
`endif
    #1 reset_n = 1'b0;
    #2 checkOutput("reset_outputs", observed, RESET_TUPLE);
    waitCycles(3);
    #2 reset_n = 1'b1;
    measureFrame(16'd2);

    applyStimulus(2'd1, 8'd0, 8'd0, 8'd0);
    waitFrameStart("fs_ramp_begin");
    waitFrameStart("fs_ramp_end");

    applyStimulus(2'd3, 8'd0, 8'd0, 8'd0);
    waitFrameStart("fs_check_begin");
    waitFrameStart("fs_check_end");

    // Solid request lands mid-frame; bars must persist until the next frame.
    applyStimulus(2'd0, 8'd0, 8'd0, 8'd0);
    waitFrameStart("fs_bars_a");
    waitFrameStart("fs_bars_b");
    waitCycles(3 * HT);
    applyStimulus(2'd2, 8'd81, 8'd90, 8'd240);
    waitFrameStart("fs_solid_begin");
    checkOutput("solid_px0", 36'({data_Y, data_Cb_Cr}), 36'(px0_exp));
    @(negedge pixel_clk);
    checkOutput("solid_px1", 36'({data_Y, data_Cb_Cr}), 36'(px1_exp));
    waitFrameStart("fs_solid_end");

    waitFrameStart("fs_pre_reset");
    waitCycles(4 * HT + 100);
    #2 reset_n = 1'b0;
    #1 checkOutput("async_reset_mid_frame", observed, RESET_TUPLE);
    waitCycles(2);
    #2 reset_n = 1'b1;
    @(negedge pixel_clk);
    checkOutput("post_reset_cycle1", 36'({data_enable, frame_start, frame_cnt}), 36'({2'b00, 16'd0}));
    @(negedge pixel_clk);
    checkOutput("post_reset_cycle2", 36'({data_enable, frame_start, frame_cnt}), 36'({2'b11, 16'd1}));
    measureFrame(16'd3);

    for (int f = 0; f < 3; f++) begin
      waitCycles($urandom_range(50, FRAME));
      applyStimulus(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    waitFrameStart("fs_random_a");
    waitFrameStart("fs_random_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
